// File: rtl/sc_match_scheduler.sv
// Match-request scheduler: per-slot pending/time buffer with a round-robin grant
// presented over a valid/ready handshake, plus drop accounting for overwritten requests.
module sc_match_scheduler #(
    parameter int N_SLOTS = 37,
    parameter int TW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TW-1:0]         song_time,
    input  logic [N_SLOTS-1:0]    match_trigger,
    input  logic [N_SLOTS*TW-1:0] match_time,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [5:0]            out_slot,
    output logic [TW-1:0]         out_dt,
    output logic [5:0]            pending_count,
    output logic                  drop_pulse,
    output logic [7:0]            drop_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                     state, state_nxt;
    logic [N_SLOTS-1:0]         pending, pending_nxt, grant_mask, drop_vec;
    logic [N_SLOTS-1:0][TW-1:0] ltime;
    logic [5:0]                 rr_ptr, sel;
    logic [6:0]                 idx;
    logic                       found, load;
    logic [5:0]                 cnt_nxt, drop_n;
    logic [8:0]                 drop_sum;

    // Round-robin pick: first pending slot at or after rr_ptr, wrapping at N_SLOTS.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            idx = {1'b0, rr_ptr} + 7'(i);
            if (idx >= 7'(N_SLOTS))
                idx = idx - 7'(N_SLOTS);
            if (!found && pending[idx[5:0]]) begin
                found = 1'b1;
                sel   = idx[5:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (found) load = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
        endcase
    end

    // A trigger on the slot being granted this cycle re-arms it without counting a drop.
    always_comb begin
        grant_mask = '0;
        if (load) grant_mask[sel] = 1'b1;
        drop_vec    = match_trigger & pending & ~grant_mask;
        pending_nxt = (pending & ~grant_mask) | match_trigger;
        cnt_nxt     = '0;
        drop_n      = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            cnt_nxt = cnt_nxt + 6'(pending_nxt[k]);
            drop_n  = drop_n + 6'(drop_vec[k]);
        end
        drop_sum = {1'b0, drop_count} + 9'(drop_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            ltime         <= '0;
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_slot      <= '0;
            out_dt        <= '0;
            pending_count <= '0;
            drop_pulse    <= 1'b0;
            drop_count    <= '0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            pending_count <= cnt_nxt;
            drop_pulse    <= |drop_vec;
            drop_count    <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            out_valid     <= (state_nxt == HOLD);
            for (int k = 0; k < N_SLOTS; k++)
                if (match_trigger[k])
                    ltime[k] <= match_time[k*TW +: TW];
            if (load) begin
                out_slot <= sel;
                out_dt   <= song_time - ltime[sel];
                rr_ptr   <= (sel == 6'(N_SLOTS-1)) ? 6'd0 : sel + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_sc_match_scheduler.sv
// Bench for sc_match_scheduler: directed scenarios then random traffic, all outputs
// compared every cycle against a slot-array reference model.
module tb_sc_match_scheduler;
    localparam int N  = 37;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [TW-1:0]   song_time = '0;
    logic [N-1:0]    match_trigger = '0;
    logic [N*TW-1:0] match_time = '0;
    logic            out_ready = 1'b1;
    logic            out_valid;
    logic [5:0]      out_slot;
    logic [TW-1:0]   out_dt;
    logic [5:0]      pending_count;
    logic            drop_pulse;
    logic [7:0]      drop_count;

    sc_match_scheduler #(.N_SLOTS(N), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .song_time(song_time),
        .match_trigger(match_trigger), .match_time(match_time),
        .out_ready(out_ready), .out_valid(out_valid), .out_slot(out_slot),
        .out_dt(out_dt), .pending_count(pending_count),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_pend[N];
    int m_tm[N];
    int m_rr, m_slot, m_dt, m_cnt, m_dcnt;
    bit m_valid, m_dp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int win, drops;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_tm[k] = 0; end
            m_rr = 0; m_valid = 0; m_slot = 0; m_dt = 0; m_cnt = 0; m_dp = 0; m_dcnt = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && m_pend[(m_rr + i) % N]) win = (m_rr + i) % N;
        if (!m_valid || out_ready) begin
            if (win >= 0) begin
                m_valid = 1;
                m_slot  = win;
                m_dt    = (int'(song_time) - m_tm[win]) & 'hFFFF;
                m_pend[win] = 0;
                m_rr    = (win + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        drops = 0;
        for (int k = 0; k < N; k++)
            if (match_trigger[k]) begin
                if (m_pend[k]) drops++;
                m_pend[k] = 1;
                m_tm[k]   = int'(match_time[k*TW +: TW]);
            end
        m_dp   = (drops > 0);
        m_dcnt = (m_dcnt + drops > 255) ? 255 : m_dcnt + drops;
        m_cnt  = 0;
        for (int k = 0; k < N; k++) m_cnt += int'(m_pend[k]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_slot", out_slot, m_slot);
        chk("out_dt", out_dt, m_dt);
        chk("pending_count", pending_count, m_cnt);
        chk("drop_pulse", drop_pulse, m_dp);
        chk("drop_count", drop_count, m_dcnt);
    endtask

    task automatic trig(input int k, input int t);
        match_trigger[k] = 1'b1;
        match_time[k*TW +: TW] = TW'(t);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        cycle(); cycle();
        chk("rst_valid", out_valid, 0);
        chk("rst_count", pending_count, 0);
        rst_n = 1'b1;

        // Single trigger latency and dt
        out_ready = 1; song_time = 100;
        trig(0, 93); cycle();
        chk("lat_t1_valid", out_valid, 0);
        match_trigger = '0; cycle();
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_slot", out_slot, 0);
        chk("lat_dt", out_dt, 7);
        cycle();
        chk("lat_t3_valid", out_valid, 0);

        // Three simultaneous triggers
        trig(3, 10); trig(10, 20); trig(36, 30); cycle();
        chk("multi_cnt0", pending_count, 3);
        match_trigger = '0; cycle();
        chk("multi_slot0", out_slot, 3);  chk("multi_cnt1", pending_count, 2);
        cycle();
        chk("multi_slot1", out_slot, 10); chk("multi_cnt2", pending_count, 1);
        cycle();
        chk("multi_slot2", out_slot, 36); chk("multi_cnt3", pending_count, 0);
        cycle();

        // Round-robin wrap: after granting 10, slots 5 and 20 -> 20 then 5
        trig(10, 1); cycle();
        match_trigger = '0; cycle();
        chk("rr_slot10", out_slot, 10);
        trig(5, 2); trig(20, 3); cycle();
        match_trigger = '0; cycle();
        chk("rr_first", out_slot, 20);
        cycle();
        chk("rr_second", out_slot, 5);
        cycle();

        // Backpressure: slot 2 held while song_time advances
        out_ready = 0; song_time = 500;
        trig(2, 480); cycle();
        match_trigger = '0; cycle();
        for (int i = 0; i < 5; i++) begin
            song_time = song_time + 16'd7;
            cycle();
            chk("hold_valid", out_valid, 1);
            chk("hold_slot", out_slot, 2);
            chk("hold_dt", out_dt, 20);
        end
        out_ready = 1; cycle();
        chk("hold_release", out_valid, 0);

        // Overwrite while blocked -> one drop, grant uses the newer time
        out_ready = 0; song_time = 200;
        trig(7, 150); cycle();
        match_trigger = '0; cycle();
        trig(4, 50); cycle();
        chk("drop_none_yet", drop_pulse, 0);
        trig(4, 60); cycle();
        chk("drop_pulse", drop_pulse, 1);
        chk("drop_count", drop_count, 1);
        match_trigger = '0; cycle();
        chk("drop_pulse_off", drop_pulse, 0);
        out_ready = 1; cycle();
        chk("drop_grant_slot", out_slot, 4);
        chk("drop_grant_dt", out_dt, 140);

        // dt wraparound, then reset mid-HOLD with a trigger that must be ignored
        song_time = 3;
        trig(1, 65533); cycle();
        match_trigger = '0; cycle();
        chk("wrap_slot", out_slot, 1);
        chk("wrap_dt", out_dt, 6);
        out_ready = 0;
        trig(8, 9); cycle();
        match_trigger = '0;
        rst_n = 0; trig(9, 11); cycle();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", pending_count, 0);
        match_trigger = '0; rst_n = 1; out_ready = 1; cycle();
        chk("postrst_valid", out_valid, 0);
        chk("postrst_count", pending_count, 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            song_time = song_time + TW'($urandom_range(0, 3));
            for (int k = 0; k < N; k++) begin
                match_trigger[k] = ($urandom_range(0, 19) == 0);
                match_time[k*TW +: TW] = TW'($urandom);
            end
            cycle();
        end

        // Drop counter saturation
        rst_n = 1; out_ready = 0;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < N; k++) trig(k, $urandom_range(0, 65535));
            cycle();
        end
        match_trigger = '0; cycle();
        chk("drop_sat", drop_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sc_match_scheduler.md
SC_MATCH_SCHEDULER -- requirements
Module: sc_match_scheduler

Interface
REQ-001 SHALL have parameter N_SLOTS, default 37, number of match buffer slots.
REQ-002 SHALL have parameter TW, default 16, timestamp width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port song_time, input, TW, current song time.
REQ-006 SHALL have port match_trigger, input, N_SLOTS, one-cycle match request per slot.
REQ-007 SHALL have port match_time, input, N_SLOTS*TW, note time per slot; slot k at bits [k*TW +: TW].
REQ-008 SHALL have port out_ready, input, 1, downstream score unit accepts.
REQ-009 SHALL have port out_valid, output, 1, granted match presented.
REQ-010 SHALL have port out_slot, output, 6, granted slot index.
REQ-011 SHALL have port out_dt, output, TW, song_time minus latched note time.
REQ-012 SHALL have port pending_count, output, 6, number of pending slots.
REQ-013 SHALL have port drop_pulse, output, 1, one-cycle flag for an overwritten pending request.
REQ-014 SHALL have port drop_count, output, 8, saturating count of drops.

Function
REQ-015 SHALL keep one pending bit and one TW-bit latched time per slot.
REQ-016 SHALL, for match_trigger[k]=1 at edge t: set pending[k] and latch match_time slot k at t, visible from t+1.
REQ-017 SHALL use FSM states IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-018 SHALL, in IDLE with any pending bit set: load output registers, clear the selected pending bit, and go to HOLD.
REQ-019 SHALL, in HOLD with out_ready=1: load the next pending slot if one exists and stay in HOLD; otherwise go to IDLE.
REQ-020 SHALL, in HOLD with out_ready=0: hold out_slot and out_dt stable and keep out_valid=1.
REQ-021 SHALL set minimum latency from trigger edge t to out_valid at t+2, with sustained throughput of one grant per cycle.
REQ-022 SHALL select round-robin: search starts at rr_ptr and scans ascending with wrap N_SLOTS-1 to 0; first pending slot wins.
REQ-023 SHALL set rr_ptr to k+1 after granting slot k, with k=N_SLOTS-1 wrapping to 0.
REQ-024 SHALL compute out_dt at load as song_time minus latched time, modulo 2^TW, unsigned wrap, no saturation.
REQ-025 SHALL, when a trigger hits a pending slot not loaded that cycle: overwrite the time, keep pending, pulse drop_pulse the next cycle, and increment drop_count, saturating at 255.
REQ-026 SHALL, when a trigger hits the slot being loaded that same cycle: give the old time to the output and leave pending=1 with the new time, with no drop.
REQ-027 SHALL accept simultaneous triggers on multiple slots in one cycle, all registered.
REQ-028 SHALL register pending_count as the popcount of pending after the cycle's updates, range 0..37.
REQ-029 SHALL ignore match_time for slots whose trigger is 0.

Reset
REQ-030 SHALL, with rst_n=0 at an edge, clear all pending bits, clear latched times, set rr_ptr=0, enter IDLE, and set out_valid=0, out_slot=0, out_dt=0, pending_count=0, drop_pulse=0, drop_count=0.
REQ-031 SHALL, when reset is asserted mid-HOLD, discard the presented grant and all pending requests; no output persists.
REQ-032 SHALL ignore triggers in cycles where rst_n=0.

Verification
REQ-033 SHALL cover: out_ready=1, song_time=100, trigger slot 0 with time 93 -> out_valid at t+2, out_slot=0, out_dt=7 for one cycle.
REQ-034 SHALL cover: slots 3, 10 and 36 triggered together, out_ready=1 -> grants 3, 10, 36 on consecutive cycles, pending_count 3,2,1,0.
REQ-035 SHALL cover: rr_ptr=11 after granting 10, then slots 5 and 20 pending -> grants 20, then 5 (wrap).
REQ-036 SHALL cover: out_ready=0 for 5 cycles with slot 2 granted -> out_slot and out_dt unchanged while song_time advances; released on out_ready=1.
REQ-037 SHALL cover: slot 4 triggered twice while blocked, times 50 then 60 -> drop_pulse once, drop_count=1, grant shows dt from time 60.
REQ-038 SHALL cover: song_time=3, latched time 65533 -> out_dt=6; rst_n=0 mid-HOLD -> out_valid=0 next cycle, pending_count=0.
